line_window_buffer: RTL and testbench

Parametrised multi-line pixel buffer. It accepts a raster-ordered pixel stream and presents a vertical column of `TAPS` pixels on every accepted pixel: the same column from the current row and from the `TAPS-1` rows above it. Rows not yet received in the current frame are zero-padded. It also reports the position of each output pixel and flags when the window is fully populated. It sits between the pixel source (camera/Bayer stage) and the convolution/filter stage of the image pipeline.

---
 rtl/line_window_buffer.sv | 119 +++++++++++
 tb/tb_line_window_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/line_window_buffer.sv
// Multi-line pixel window: presents a vertical column of TAPS pixels (current row
// plus TAPS-1 rows above) for every accepted raster-order pixel, zero-padded at frame top.
module line_window_buffer #(
    parameter int DATA_W  = 12,
    parameter int LINE_W  = 640,
    parameter int FRAME_H = 480,
    parameter int TAPS    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       sof,
    input  logic [DATA_W-1:0]          pixel_in,
    output logic [TAPS*DATA_W-1:0]     taps_out,
    output logic                       out_valid,
    output logic [$clog2(LINE_W)-1:0]  out_col,
    output logic [$clog2(FRAME_H)-1:0] out_row,
    output logic                       win_full
);

    localparam int COL_W  = $clog2(LINE_W);
    localparam int ROW_W  = $clog2(FRAME_H);
    localparam int NLINES = TAPS - 1;
    localparam int SLOT_W = (NLINES > 1) ? $clog2(NLINES) : 1;

    // Rows rotate through the line memories instead of being shifted between
    // them, so each memory sees exactly one read and at most one write per pixel.
    function automatic logic [SLOT_W-1:0] tap_slot(input logic [SLOT_W-1:0] s, input int k);
        int v;
        v = int'(s) + NLINES - k;
        if (v >= NLINES) v -= NLINES;
        return SLOT_W'(v);
    endfunction

    logic [COL_W-1:0]  col, cur_col;
    logic [ROW_W-1:0]  row, cur_row;
    logic [SLOT_W-1:0] slot, cur_slot;
    logic              last_col, last_row;

    logic [DATA_W-1:0] mem [NLINES][LINE_W];
    logic [DATA_W-1:0] rd_q [NLINES];
    logic [SLOT_W-1:0] sel_q [1:TAPS-1];
    logic [TAPS-1:1]   pad_q;
    logic [DATA_W-1:0] tap0_q;

    // NOTE: always_comb assigns every output on every path, so no latch is inferred.
    always_comb begin
        cur_col  = col;
        cur_row  = row;
        cur_slot = slot;
        if (sof) begin
            cur_col  = '0;
            cur_row  = '0;
            cur_slot = '0;
        end
        last_col = (cur_col == COL_W'(LINE_W - 1));
        last_row = (cur_row == ROW_W'(FRAME_H - 1));
    end

    // NOTE: line memories have no reset; stale contents are hidden by pad_q instead.
    always_ff @(posedge clk) begin
        if (en && !rst) begin
            for (int s = 0; s < NLINES; s++) begin
                if (cur_slot == SLOT_W'(s))
                    mem[s][cur_col] <= pixel_in;
                rd_q[s] <= mem[s][cur_col];
            end
        end
    end

    // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            slot      <= '0;
            out_valid <= 1'b0;
            out_col   <= '0;
            out_row   <= '0;
            win_full  <= 1'b0;
            tap0_q    <= '0;
            pad_q     <= '1;
            for (int k = 1; k < TAPS; k++) sel_q[k] <= '0;
        end else begin
            out_valid <= en;
            if (en) begin
                tap0_q   <= pixel_in;
                out_col  <= cur_col;
                out_row  <= cur_row;
                win_full <= (cur_row >= ROW_W'(TAPS - 1));
                for (int k = 1; k < TAPS; k++) begin
                    pad_q[k] <= (cur_row < ROW_W'(k));
                    sel_q[k] <= tap_slot(cur_slot, k);
                end
                if (last_col) begin
                    col <= '0;
                    if (last_row) begin
                        row  <= '0;
                        slot <= '0;
                    end else begin
                        row  <= cur_row + 1'b1;
                        slot <= (cur_slot == SLOT_W'(NLINES - 1)) ? '0 : cur_slot + 1'b1;
                    end
                end else begin
                    col  <= cur_col + 1'b1;
                    row  <= cur_row;
                    slot <= cur_slot;
                end
            end
        end
    end

    assign taps_out[DATA_W-1:0] = tap0_q;

    for (genvar k = 1; k < TAPS; k++) begin : g_tap
        assign taps_out[DATA_W*k +: DATA_W] = pad_q[k] ? '0 : rd_q[sel_q[k]];
    end

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer on a 4x4 frame with a 3-row window;
// a small image scoreboard supplies per-pixel expectations alongside hand-computed values.
module tb_line_window_buffer;

    localparam int DATA_W  = 12;
    localparam int LINE_W  = 4;
    localparam int FRAME_H = 4;
    localparam int TAPS    = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic                   sof;
    logic [DATA_W-1:0]      pixel_in;
    logic [TAPS*DATA_W-1:0] taps_out;
    logic                   out_valid;
    logic [1:0]             out_col;
    logic [1:0]             out_row;
    logic                   win_full;

    line_window_buffer #(
        .DATA_W(DATA_W), .LINE_W(LINE_W), .FRAME_H(FRAME_H), .TAPS(TAPS)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sof(sof), .pixel_in(pixel_in),
        .taps_out(taps_out), .out_valid(out_valid), .out_col(out_col),
        .out_row(out_row), .win_full(win_full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0]      img [FRAME_H][LINE_W];
    int                     er, ec;
    logic [TAPS*DATA_W-1:0] last_taps;
    int                     last_r, last_c;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Accept one pixel and compare the resulting output against the scoreboard.
    task automatic push(input logic [DATA_W-1:0] pix, input logic s);
        int r, c;
        logic [TAPS*DATA_W-1:0] exp;
        if (s) begin er = 0; ec = 0; end
        r = er; c = ec;
        exp = {(r >= 2) ? img[r-2][c] : 12'h000, (r >= 1) ? img[r-1][c] : 12'h000, pix};
        img[r][c] = pix;
        en = 1'b1; sof = s; pixel_in = pix;
        @(posedge clk); #1;
        en = 1'b0; sof = 1'b0;
        check($sformatf("valid(%0d,%0d)", r, c), 64'(out_valid), 64'd1);
        check($sformatf("row(%0d,%0d)", r, c), 64'(out_row), 64'(r));
        check($sformatf("col(%0d,%0d)", r, c), 64'(out_col), 64'(c));
        check($sformatf("taps(%0d,%0d)", r, c), 64'(taps_out), 64'(exp));
        check($sformatf("full(%0d,%0d)", r, c), 64'(win_full), 64'(r >= 2));
        last_taps = exp; last_r = r; last_c = c;
        if (ec == LINE_W - 1) begin
            ec = 0;
            er = (er == FRAME_H - 1) ? 0 : er + 1;
        end else begin
            ec++;
        end
    endtask

    task automatic push_pos();
        push(12'(er * 16 + ec), 1'b0);
    endtask

    task automatic idle(input string tag);
        en = 1'b0; sof = 1'b1; pixel_in = 12'hEEE;
        @(posedge clk); #1;
        sof = 1'b0;
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_taps_hold"}, 64'(taps_out), 64'(last_taps));
        check({tag, "_col_hold"}, 64'(out_col), 64'(last_c));
        check({tag, "_row_hold"}, 64'(out_row), 64'(last_r));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_taps"}, 64'(taps_out), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_col"}, 64'(out_col), 64'd0);
        check({tag, "_row"}, 64'(out_row), 64'd0);
        check({tag, "_full"}, 64'(win_full), 64'd0);
    endtask

    initial begin
        er = 0; ec = 0;
        for (int r = 0; r < FRAME_H; r++)
            for (int c = 0; c < LINE_W; c++) img[r][c] = 12'h000;

        // Reset with a pixel presented: it must be dropped.
        rst = 1'b1; en = 1'b1; sof = 1'b1; pixel_in = 12'hFFF;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0; en = 1'b0; sof = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset_valid", 64'(out_valid), 64'd0);

        // Fill and padding: one continuous frame.
        for (int r = 0; r < FRAME_H; r++) begin
            for (int c = 0; c < LINE_W; c++) begin
                push(12'(r * 16 + c), (r == 0 && c == 0));
                if (r == 0 && c == 0)
                    check("pad_0_0_upper", 64'(taps_out[35:12]), 64'd0);
                if (r == 1 && c == 3) begin
                    check("pad_1_3_taps", 64'(taps_out), 64'h000_003_013);
                    check("pad_1_3_full", 64'(win_full), 64'd0);
                end
                if (r == 2 && c == 1) begin
                    check("fill_2_1_taps", 64'(taps_out), 64'h001_011_021);
                    check("fill_2_1_full", 64'(win_full), 64'd1);
                end
            end
        end

        // Gaps in en through row 2 of a fresh frame.
        push(12'h000, 1'b1);
        for (int i = 1; i < 2 * LINE_W; i++) push_pos();
        for (int c = 0; c < LINE_W; c++) begin
            push_pos();
            if (c == 1) check("gap_2_1_taps", 64'(taps_out), 64'h001_011_021);
            if (c < LINE_W - 1) begin
                idle($sformatf("gap%0d_a", c));
                idle($sformatf("gap%0d_b", c));
            end
        end
        for (int c = 0; c < LINE_W; c++) push_pos();

        // Implicit frame wrap on the 17th pixel.
        push(12'hABC, 1'b0);
        check("wrap_taps", 64'(taps_out), 64'h000_000_ABC);
        check("wrap_row", 64'(out_row), 64'd0);
        check("wrap_col", 64'(out_col), 64'd0);
        check("wrap_full", 64'(win_full), 64'd0);

        // Mid-line sof at (2,2).
        while (!(er == 2 && ec == 2)) push_pos();
        push(12'h555, 1'b1);
        check("sof_taps", 64'(taps_out), 64'h000_000_555);
        check("sof_row", 64'(out_row), 64'd0);
        check("sof_col", 64'(out_col), 64'd0);
        push_pos();
        check("sof_next_col", 64'(out_col), 64'd1);

        // Reset mid-frame at (3,2) with en held high.
        while (!(er == 3 && ec == 2)) push_pos();
        check("pre_reset_full", 64'(win_full), 64'd1);
        rst = 1'b1; en = 1'b1; pixel_in = 12'h032;
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b0;
        check_zero_outputs("midreset");
        er = 0; ec = 0;
        push(12'h777, 1'b0);
        check("post_reset_taps", 64'(taps_out), 64'h000_000_777);
        check("post_reset_pos", 64'({out_row, out_col}), 64'd0);
        push_pos();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
